// File: rtl/display_pkg.sv
// Shared constants and types for the background label ROM arbiter.
package display_pkg;

    localparam int H_RES      = 320;   // native background width
    localparam int V_RES      = 220;   // native background height
    localparam int PIXEL_BITS = 3;     // label width
    localparam int ADDR_BITS  = 17;    // ceil(log2(H_RES*V_RES))

    // Coordinate widths on the native (un-doubled) grid
    localparam int NX_BITS = 9;
    localparam int NY_BITS = 8;

    // Query port state machine
    typedef enum logic [1:0] {
        Q_IDLE,
        Q_WAIT,
        Q_READ,
        Q_DONE
    } q_state_t;

endpackage

// File: rtl/bg_addr_calc.sv
// Native-grid coordinate to ROM address conversion with a range flag.
// The row stride of 320 is built from two shifts (256 + 64).
module bg_addr_calc
    import display_pkg::*;
(
    input  logic [NX_BITS-1:0]   i_x,
    input  logic [NY_BITS-1:0]   i_y,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic                 o_in_range
);

    logic [ADDR_BITS-1:0] w_x_ext;
    logic [ADDR_BITS-1:0] w_y_ext;

    assign w_x_ext = {{(ADDR_BITS-NX_BITS){1'b0}}, i_x};
    assign w_y_ext = {{(ADDR_BITS-NY_BITS){1'b0}}, i_y};

    // Full-width sum; out-of-range coordinates still fit in 17 bits, the
    // result is simply not used for them.
    assign o_addr     = (w_y_ext << 8) + (w_y_ext << 6) + w_x_ext;
    assign o_in_range = (i_x < NX_BITS'(H_RES)) && (i_y < NY_BITS'(V_RES));

endmodule

// File: rtl/bg_rom_arbiter.sv
// Shares the single-port background label ROM between the VGA scan-out
// (absolute priority, fixed 2-cycle latency) and a req/ack query port.
// Doubled pixels reuse the previous read, which frees a slot every odd x.
module bg_rom_arbiter
    import display_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vga_req,
    input  logic [9:0]            i_vga_x,
    input  logic [8:0]            i_vga_y,
    output logic                  o_vga_valid,
    output logic [PIXEL_BITS-1:0] o_vga_label,
    input  logic                  i_q_req,
    input  logic [8:0]            i_q_x,
    input  logic [7:0]            i_q_y,
    output logic                  o_q_ack,
    output logic [PIXEL_BITS-1:0] o_q_label,
    output logic                  o_q_busy,
    output logic [ADDR_BITS-1:0]  o_rom_addr,
    output logic                  o_rom_en,
    input  logic [PIXEL_BITS-1:0] i_rom_data
);

    // Address generation
    logic [ADDR_BITS-1:0]  w_vga_addr;
    logic                  w_vga_in_range;
    logic [ADDR_BITS-1:0]  w_q_addr;
    logic                  w_q_in_range;
    logic [NX_BITS-1:0]    w_q_src_x;
    logic [NY_BITS-1:0]    w_q_src_y;
    logic                  w_vga_y_lsb_unused;

    // Slot decisions
    logic                  w_vga_reuse;
    logic                  w_vga_rd;
    logic                  w_q_rd;

    // Registered state
    logic [ADDR_BITS-1:0]  r_rom_addr_hold;
    logic [ADDR_BITS-1:0]  r_prev_vga_addr;
    logic                  r_prev_vga_read;
    logic                  r_s1_valid;
    logic                  r_s1_rom;
    logic                  r_s1_reuse;
    logic                  r_vga_valid;
    logic [PIXEL_BITS-1:0] r_vga_label;
    q_state_t              r_q_state;
    logic [NX_BITS-1:0]    r_q_x;
    logic [NY_BITS-1:0]    r_q_y;
    logic                  r_q_ack;
    logic                  r_q_busy;
    logic [PIXEL_BITS-1:0] r_q_label;

    // The row LSB only selects the doubled line, it never reaches the ROM.
    assign w_vga_y_lsb_unused = i_vga_y[0];

    // The query address comes straight from the port while idle so that an
    // accepted query can issue in its accept cycle; afterwards it comes from
    // the latched coordinates.
    assign w_q_src_x = (r_q_state == Q_IDLE) ? i_q_x : r_q_x;
    assign w_q_src_y = (r_q_state == Q_IDLE) ? i_q_y : r_q_y;

    bg_addr_calc u_vga_addr (
        .i_x        (i_vga_x[9:1]),
        .i_y        (i_vga_y[8:1]),
        .o_addr     (w_vga_addr),
        .o_in_range (w_vga_in_range)
    );

    bg_addr_calc u_q_addr (
        .i_x        (w_q_src_x),
        .i_y        (w_q_src_y),
        .o_addr     (w_q_addr),
        .o_in_range (w_q_in_range)
    );

    // Second half of a doubled pixel: the label already read last cycle
    // is still valid, so the ROM slot is handed to the query port.
    assign w_vga_reuse = r_prev_vga_read && i_vga_x[0] &&
                         (w_vga_addr == r_prev_vga_addr);

    assign w_vga_rd = !i_rst && i_vga_req && w_vga_in_range && !w_vga_reuse;

    assign w_q_rd = !i_rst && !w_vga_rd &&
                    (((r_q_state == Q_IDLE) && i_q_req && w_q_in_range) ||
                     (r_q_state == Q_WAIT));

    assign o_rom_en   = w_vga_rd || w_q_rd;
    assign o_rom_addr = w_vga_rd ? w_vga_addr :
                        w_q_rd   ? w_q_addr   : r_rom_addr_hold;

    // Remember the last issued address and the last VGA read for reuse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rom_addr_hold <= '0;
            r_prev_vga_addr <= '0;
            r_prev_vga_read <= 1'b0;
        end else begin
            if (o_rom_en) begin
                r_rom_addr_hold <= o_rom_addr;
            end
            if (w_vga_rd) begin
                r_prev_vga_addr <= w_vga_addr;
            end
            r_prev_vga_read <= w_vga_rd;
        end
    end

    // Two-stage VGA pipeline: stage 1 records how the label will be sourced,
    // stage 2 registers the label once ROM data is available.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_rom    <= 1'b0;
            r_s1_reuse  <= 1'b0;
            r_vga_valid <= 1'b0;
            r_vga_label <= '0;
        end else begin
            r_s1_valid  <= i_vga_req;
            r_s1_rom    <= w_vga_rd;
            r_s1_reuse  <= i_vga_req && w_vga_in_range && w_vga_reuse;
            r_vga_valid <= r_s1_valid;
            // A reused pixel follows its read by exactly one cycle, so the
            // output register currently holds the matching label.
            if (r_s1_rom) begin
                r_vga_label <= i_rom_data;
            end else if (r_s1_reuse) begin
                r_vga_label <= r_vga_label;
            end else begin
                r_vga_label <= '0;
            end
        end
    end

    // Query handshake FSM: accept, wait for a free slot, read, acknowledge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q_state <= Q_IDLE;
            r_q_x     <= '0;
            r_q_y     <= '0;
            r_q_ack   <= 1'b0;
            r_q_busy  <= 1'b0;
            r_q_label <= '0;
        end else begin
            r_q_ack <= 1'b0;
            case (r_q_state)
                Q_IDLE: begin
                    if (i_q_req) begin
                        r_q_x    <= i_q_x;
                        r_q_y    <= i_q_y;
                        r_q_busy <= 1'b1;
                        if (!w_q_in_range) begin
                            r_q_label <= '0;
                            r_q_ack   <= 1'b1;
                            r_q_state <= Q_DONE;
                        end else if (w_q_rd) begin
                            r_q_state <= Q_READ;
                        end else begin
                            r_q_state <= Q_WAIT;
                        end
                    end
                end
                Q_WAIT: begin
                    if (w_q_rd) begin
                        r_q_state <= Q_READ;
                    end
                end
                Q_READ: begin
                    r_q_label <= i_rom_data;
                    r_q_ack   <= 1'b1;
                    r_q_state <= Q_DONE;
                end
                Q_DONE: begin
                    r_q_busy  <= 1'b0;
                    r_q_state <= Q_IDLE;
                end
                default: begin
                    r_q_busy  <= 1'b0;
                    r_q_state <= Q_IDLE;
                end
            endcase
        end
    end

    assign o_vga_valid = r_vga_valid;
    assign o_vga_label = r_vga_label;
    assign o_q_ack     = r_q_ack;
    assign o_q_busy    = r_q_busy;
    assign o_q_label   = r_q_label;

endmodule
